// File: rtl/system_widths_pkg.sv
// rtl/system_widths_pkg.sv - shared widths and FSM state type for the byte cache
//
// Purpose: common address width, default cache index width and the cache
// controller state enumeration, imported by cache_ctrl and cache_tag_array.
package system_widths_pkg;

   localparam int ADDR_W        = 8;
   localparam int CACHE_INDEX_W = 4;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      MISS_REQ  = 3'd1,
      MISS_WAIT = 3'd2,
      WR_REQ    = 3'd3,
      WR_WAIT   = 3'd4
   } cache_state_e;

endpackage

// File: rtl/cache_tag_array.sv
// rtl/cache_tag_array.sv - valid/tag/data storage for the direct-mapped byte cache
//
// Purpose: one-byte lines with a valid bit and tag each. Combinational lookup,
// one synchronous write port (fill = allocate line, update = data only).
// Ports:
//   clk, resetN             clock, synchronous active-low reset (clears valid bits)
//   i_rd_index, i_rd_tag    lookup address split
//   o_hit, o_rd_data        lookup result
//   i_wr_en, i_wr_fill      write strobe; fill also sets valid and tag
//   i_wr_index, i_wr_tag    write address split
//   i_wr_data               byte written into the line
module cache_tag_array
   import system_widths_pkg::*;
#(
   parameter int INDEX_W = CACHE_INDEX_W,
   parameter int TAG_W   = ADDR_W - INDEX_W
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic [INDEX_W-1:0] i_rd_index,
   input  logic [TAG_W-1:0]   i_rd_tag,
   output logic               o_hit,
   output logic [7:0]         o_rd_data,
   input  logic               i_wr_en,
   input  logic               i_wr_fill,
   input  logic [INDEX_W-1:0] i_wr_index,
   input  logic [TAG_W-1:0]   i_wr_tag,
   input  logic [7:0]         i_wr_data
);

   localparam int LINES = 1 << INDEX_W;

   logic [LINES-1:0] r_valid;
   logic [TAG_W-1:0] r_tag  [LINES];
   logic [7:0]       r_data [LINES];

   assign o_hit     = r_valid[i_rd_index] && (r_tag[i_rd_index] == i_rd_tag);
   assign o_rd_data = r_data[i_rd_index];

   // Only the valid bits need reset; stale tag/data are masked by valid=0.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         r_valid <= '0;
      end else if (i_wr_en && i_wr_fill) begin
         r_valid[i_wr_index] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_data[i_wr_index] <= i_wr_data;
         if (i_wr_fill) begin
            r_tag[i_wr_index] <= i_wr_tag;
         end
      end
   end

endmodule

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - direct-mapped write-through no-write-allocate byte cache controller
//
// Purpose: serves CPU load hits in one cycle, forwards load misses and all
// stores to memory with at most one outstanding memory transaction.
// Ports:
//   clk, resetN                       clock, synchronous active-low reset
//   cpu_req_valid/ready/we/addr/wdata CPU request handshake (ready only in IDLE)
//   cpu_resp_valid, cpu_resp_rdata    one-cycle completion pulse, load data (0 for stores)
//   mem_req_valid/ready/we/addr/write registered memory request, held while stalled
//   mem_resp_valid, mem_resp_data     memory completion pulse and read data
module cache_ctrl
   import system_widths_pkg::*;
#(
   parameter int INDEX_W = CACHE_INDEX_W,
   parameter int TAG_W   = ADDR_W - INDEX_W
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              cpu_req_valid,
   output logic              cpu_req_ready,
   input  logic              cpu_req_we,
   input  logic [ADDR_W-1:0] cpu_req_addr,
   input  logic [7:0]        cpu_req_wdata,
   output logic              cpu_resp_valid,
   output logic [7:0]        cpu_resp_rdata,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_we,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [7:0]        mem_req_write,
   input  logic              mem_resp_valid,
   input  logic [7:0]        mem_resp_data
);

   cache_state_e      r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_wdata;
   logic              r_store_hit;

   logic              w_hit;
   logic [7:0]        w_rd_data;
   logic              w_wr_en;
   logic              w_wr_fill;
   logic [7:0]        w_wr_data;

   assign cpu_req_ready = resetN && (r_state == IDLE);

   // Lookup uses the live CPU address (decision made in IDLE); writes use the
   // address latched at accept, after memory has acknowledged.
   assign w_wr_fill = (r_state == MISS_WAIT);
   assign w_wr_en   = mem_resp_valid &&
                      ((r_state == MISS_WAIT) || ((r_state == WR_WAIT) && r_store_hit));
   assign w_wr_data = w_wr_fill ? mem_resp_data : r_wdata;

   cache_tag_array #(
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W)
   ) u_tag_array (
      .clk        (clk),
      .resetN     (resetN),
      .i_rd_index (cpu_req_addr[INDEX_W-1:0]),
      .i_rd_tag   (cpu_req_addr[ADDR_W-1:INDEX_W]),
      .o_hit      (w_hit),
      .o_rd_data  (w_rd_data),
      .i_wr_en    (w_wr_en),
      .i_wr_fill  (w_wr_fill),
      .i_wr_index (r_addr[INDEX_W-1:0]),
      .i_wr_tag   (r_addr[ADDR_W-1:INDEX_W]),
      .i_wr_data  (w_wr_data)
   );

   always_ff @(posedge clk) begin
      if (!resetN) begin
         r_state        <= IDLE;
         r_addr         <= '0;
         r_wdata        <= '0;
         r_store_hit    <= 1'b0;
         cpu_resp_valid <= 1'b0;
         cpu_resp_rdata <= '0;
         mem_req_valid  <= 1'b0;
         mem_req_we     <= 1'b0;
         mem_req_addr   <= '0;
         mem_req_write  <= '0;
      end else begin
         cpu_resp_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (cpu_req_valid) begin
                  r_addr      <= cpu_req_addr;
                  r_wdata     <= cpu_req_wdata;
                  // Remember hit status now; the line update waits for the memory ack.
                  r_store_hit <= w_hit;
                  if (cpu_req_we) begin
                     mem_req_valid <= 1'b1;
                     mem_req_we    <= 1'b1;
                     mem_req_addr  <= cpu_req_addr;
                     mem_req_write <= cpu_req_wdata;
                     r_state       <= WR_REQ;
                  end else if (w_hit) begin
                     cpu_resp_valid <= 1'b1;
                     cpu_resp_rdata <= w_rd_data;
                  end else begin
                     mem_req_valid <= 1'b1;
                     mem_req_we    <= 1'b0;
                     mem_req_addr  <= cpu_req_addr;
                     mem_req_write <= '0;
                     r_state       <= MISS_REQ;
                  end
               end
            end
            MISS_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  r_state       <= MISS_WAIT;
               end
            end
            MISS_WAIT: begin
               if (mem_resp_valid) begin
                  cpu_resp_valid <= 1'b1;
                  cpu_resp_rdata <= mem_resp_data;
                  r_state        <= IDLE;
               end
            end
            WR_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  r_state       <= WR_WAIT;
               end
            end
            WR_WAIT: begin
               if (mem_resp_valid) begin
                  cpu_resp_valid <= 1'b1;
                  cpu_resp_rdata <= '0;
                  r_state        <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate byte cache.
- Sits between the CPU load/store unit and the byte-addressable memory block; it is the master side of cache_mem_if.
- Serves load hits in 1 cycle. Forwards load misses and all stores to memory over the req/resp handshake.
- Holds at most one outstanding memory transaction.

Parameters:
- INDEX_W, 4: index bits; the cache holds 2**INDEX_W one-byte lines.
- TAG_W, ADDR_W-INDEX_W: tag bits. Derived value; do not override.

Ports:
- clk  input  1  system clock
- resetN  input  1  reset, synchronous, active-low
- cpu_req_valid  input  1  CPU request present
- cpu_req_ready  output  1  cache can accept a CPU request this cycle
- cpu_req_we  input  1  1 = store, 0 = load
- cpu_req_addr  input  ADDR_W  byte address
- cpu_req_wdata  input  8  store data
- cpu_resp_valid  output  1  one-cycle pulse: request complete
- cpu_resp_rdata  output  8  load data; 0 for stores
- mem_req_valid  output  1  request to memory
- mem_req_ready  input  1  memory accepts the request
- mem_req_we  output  1  memory write enable
- mem_req_addr  output  ADDR_W  memory byte address
- mem_req_write  output  8  memory write data
- mem_resp_valid  input  1  memory response pulse
- mem_resp_data  input  8  memory read data

Behaviour:
- Storage per line: valid bit, tag[TAG_W-1:0], data[7:0].
  - index = addr[INDEX_W-1:0]
  - tag = addr[ADDR_W-1:INDEX_W]
- Reset (resetN low at posedge clk):
  - state <= IDLE; all valid bits <= 0.
  - cpu_resp_valid = 0, cpu_resp_rdata = 0.
  - mem_req_valid = 0, mem_req_we = 0, mem_req_addr = 0, mem_req_write = 0.
  - Reset mid-transaction abandons it. No CPU response is issued for the abandoned request.
- cpu_req_ready = 1 only in IDLE and not in reset.
- Accept = cpu_req_valid && cpu_req_ready. On accept, latch we, addr and wdata.
- Memory requests: mem_req_* outputs are registered and held stable while mem_req_valid=1 && !mem_req_ready.
- States:
  - IDLE
    - Load hit (valid && tag match): on the next cycle, cpu_resp_valid=1 and cpu_resp_rdata=line data. Stay in IDLE, so back-to-back hits run at one per cycle.
    - Load miss: drive mem_req_valid=1, we=0, addr=cpu addr; go to MISS_REQ.
    - Store: drive mem_req_valid=1, we=1, addr, write=wdata; go to WR_REQ.
  - MISS_REQ: when mem_req_ready=1, mem_req_valid <= 0; go to MISS_WAIT.
  - MISS_WAIT: on mem_resp_valid:
    - Fill line: valid=1, tag, data=mem_resp_data.
    - Next cycle: cpu_resp_valid=1, cpu_resp_rdata=mem_resp_data.
    - Go to IDLE.
    - Miss latency with a 1-cycle memory: 3 cycles from accept to cpu_resp_valid.
  - WR_REQ: on ready, drop mem_req_valid; go to WR_WAIT.
  - WR_WAIT: on mem_resp_valid:
    - If the store address hit at accept time, update line data (no allocate on miss).
    - cpu_resp_valid=1 next cycle, rdata=0.
    - Go to IDLE.
- Edge cases:
  - mem_resp_valid in IDLE or *_REQ is ignored. This covers stale responses after a reset.
  - A store to a hit line updates the cache only after memory acknowledges, so a later load never returns data newer than memory.
  - A load immediately following a store waits for the store to complete, because ready=0 during WR_*.
  - A conflict miss overwrites the line; no eviction write is needed (write-through).
- cpu_resp_valid is a single-cycle pulse and is otherwise 0. cpu_resp_rdata holds its last value between pulses.

Decomposition:
- system_widths_pkg holds ADDR_W, the cache_state_e enum (IDLE, MISS_REQ, MISS_WAIT, WR_REQ, WR_WAIT) and CACHE_INDEX_W default.
- Sub-module cache_tag_array holds the valid/tag/data arrays.
  - Combinational hit/read-data lookup.
  - Synchronous write port with fill/update select.
  - Synchronous valid clear on reset.
- The FSM and handshake logic stay in cache_ctrl.

Test Plan:
- Cold load (ADDR_W=8, INDEX_W=4), memory[0x13]=0xA5, load 0x13 → mem_req (we=0, addr=0x13) seen once. cpu_resp_valid 3 cycles after accept, rdata=0xA5.
- Repeat load 0x13 → no mem_req_valid; rdata=0xA5 on the cycle after accept. 4 back-to-back hits give 4 consecutive responses.
- Store 0x13 ← 0x3C, then load 0x13 → mem write seen (addr 0x13, data 0x3C). Load hits with no mem traffic and returns 0x3C.
- Conflict: load 0x23 (same index 3, memory[0x23]=0x77) → miss, rdata=0x77. Then load 0x13 → miss again and returns 0x3C from memory.
- Hold mem_req_ready=0 for 5 cycles during a miss → mem_req_valid/addr stable for those cycles, cpu_req_ready=0, single transaction once ready rises.
- Assert resetN=0 during MISS_WAIT, then inject mem_resp_valid after release → no cpu_resp_valid. A following load to the same address misses, since valid was cleared.
